memory_bus_controller: RTL and testbench

MEMORY_BUS_CONTROLLER -- requirements
Module: memory_bus_controller

---
 rtl/memory_bus_controller_if.sv | 33 +++
 rtl/memory_bus_controller.sv | 165 ++++++++++++++++
 tb/tb_memory_bus_controller.sv | 375 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_bus_controller_if.sv
// ----------------------------------------------------------------------------
// memory_bus_controller_if
// CPU-side request/response channel of the memory bus controller.
//   req_valid/req_ready  request handshake (master -> slave)
//   req_write            1 = write, 0 = read
//   req_addr/req_wdata   byte address and write data
//   req_be               byte enables
//   rsp_valid/rsp_ready  response handshake (slave -> master)
//   rsp_rdata            read data (0 for writes and faults)
//   rsp_error            access fault
// ----------------------------------------------------------------------------
interface memory_bus_controller_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic [3:0]  req_be;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_error;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_error
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_be, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_error
   );
endinterface

// File: rtl/memory_bus_controller.sv
// ----------------------------------------------------------------------------
// memory_bus_controller
// Single-outstanding CPU-to-slave bus controller. A CPU request is latched
// onto the bus_* registers, the external decoder (rom/ram/io/gfx_sel) picks
// the slave, and the controller runs either a fixed-latency access
// (ROM/IO/GFX) or an ack-terminated access with timeout (RAM) before
// presenting one response to the CPU.
//   clk, rst                 clock, synchronous active-high reset
//   cpu                      CPU request/response channel (slave modport)
//   bus_addr/wdata/be        latched request, bus_addr feeds the decoder
//   bus_we                   write strobe while a chip select is active
//   *_sel                    decoder outputs for bus_addr
//   *_cs                     slave chip selects
//   *_rdata                  slave read data
//   ram_ack                  RAM completion
//
// state   | meaning
// IDLE    | req_ready=1, waiting for a CPU request
// ACCESS  | decode, drive chip select, wait for latency / ram_ack / timeout
// RESPOND | rsp_valid=1, holding response until rsp_ready
// ----------------------------------------------------------------------------
module memory_bus_controller #(
   parameter int ROM_WAIT    = 1,
   parameter int IO_WAIT     = 0,
   parameter int GFX_WAIT    = 1,
   parameter int RAM_TIMEOUT = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   memory_bus_controller_if.slave  cpu,
   output logic [31:0]             bus_addr,
   output logic [31:0]             bus_wdata,
   output logic [3:0]              bus_be,
   output logic                    bus_we,
   input  logic                    rom_sel,
   input  logic                    ram_sel,
   input  logic                    io_sel,
   input  logic                    gfx_sel,
   output logic                    rom_cs,
   output logic                    ram_cs,
   output logic                    io_cs,
   output logic                    gfx_cs,
   input  logic [31:0]             rom_rdata,
   input  logic [31:0]             ram_rdata,
   input  logic [31:0]             io_rdata,
   input  logic [31:0]             gfx_rdata,
   input  logic                    ram_ack
);
   typedef enum logic [1:0] {IDLE, ACCESS, RESPOND} state_t;

   state_t      state_q, state_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [3:0]  be_q, be_d;
   logic        write_q, write_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [31:0] rdata_q, rdata_d;
   logic        error_q, error_d;

   logic [2:0]  nsel;
   logic        fault;
   logic [7:0]  fixed_last;
   logic [31:0] fixed_rdata;

   // Decode of the latched address; the selects are stable for the whole
   // access because bus_addr only changes on an IDLE handshake.
   always_comb begin
      nsel        = {2'b00, rom_sel} + {2'b00, ram_sel} + {2'b00, io_sel} + {2'b00, gfx_sel};
      fault       = (nsel != 3'd1) || (rom_sel && write_q);
      fixed_last  = rom_sel ? 8'(ROM_WAIT) : (io_sel ? 8'(IO_WAIT) : 8'(GFX_WAIT));
      fixed_rdata = rom_sel ? rom_rdata : (io_sel ? io_rdata : gfx_rdata);
   end

   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      be_d    = be_q;
      write_d = write_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      error_d = error_q;
      rom_cs  = 1'b0;
      ram_cs  = 1'b0;
      io_cs   = 1'b0;
      gfx_cs  = 1'b0;
      case (state_q)
         IDLE: begin
            if (cpu.req_valid) begin
               addr_d  = cpu.req_addr;
               wdata_d = cpu.req_wdata;
               be_d    = cpu.req_be;
               write_d = cpu.req_write;
               cnt_d   = 8'd0;
               state_d = ACCESS;
            end
         end
         ACCESS: begin
            // cnt_q counts completed ACCESS cycles; it leaves ACCESS before
            // it could wrap.
            cnt_d = cnt_q + 8'd1;
            if (fault) begin
               rdata_d = 32'd0;
               error_d = 1'b1;
               state_d = RESPOND;
            end else if (ram_sel) begin
               ram_cs = 1'b1;
               if (ram_ack) begin
                  rdata_d = write_q ? 32'd0 : ram_rdata;
                  error_d = 1'b0;
                  state_d = RESPOND;
               end else if (cnt_q == 8'(RAM_TIMEOUT)) begin
                  rdata_d = 32'd0;
                  error_d = 1'b1;
                  state_d = RESPOND;
               end
            end else begin
               rom_cs = rom_sel;
               io_cs  = io_sel;
               gfx_cs = gfx_sel;
               if (cnt_q == fixed_last) begin
                  rdata_d = write_q ? 32'd0 : fixed_rdata;
                  error_d = 1'b0;
                  state_d = RESPOND;
               end
            end
         end
         RESPOND: begin
            if (cpu.rsp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         addr_q  <= 32'd0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
         write_q <= 1'b0;
         cnt_q   <= 8'd0;
         rdata_q <= 32'd0;
         error_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         be_q    <= be_d;
         write_q <= write_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         error_q <= error_d;
      end
   end

   assign cpu.req_ready = (state_q == IDLE);
   assign cpu.rsp_valid = (state_q == RESPOND);
   assign cpu.rsp_rdata = rdata_q;
   assign cpu.rsp_error = error_q;
   assign bus_addr      = addr_q;
   assign bus_wdata     = wdata_q;
   assign bus_be        = be_q;
   assign bus_we        = write_q & (rom_cs | ram_cs | io_cs | gfx_cs);
endmodule

// File: tb/tb_memory_bus_controller.sv
// ----------------------------------------------------------------------------
// tb_memory_bus_controller
// Drives CPU transactions against memory_bus_controller with a simple address
// map decoder, slave data sources and a RAM ack generator, and compares each
// transaction's observed behaviour with an address-map based reference.
// Address map (bits 31:24): 00 ROM, 08 RAM, 10 IO, 20 GFX, 30 ROM+IO
// (double select), anything else unmapped.
// ----------------------------------------------------------------------------
module tb_memory_bus_controller;
   localparam int ROM_W  = 1;
   localparam int IO_W   = 0;
   localparam int GFX_W  = 2;
   localparam int RAM_TO = 255;

   typedef struct packed {
      int          lat;
      int          c_rom;
      int          c_ram;
      int          c_io;
      int          c_gfx;
      int          we_n;
      int          bad_bus;
      int          bad_hold;
      logic [31:0] rdata;
      logic        err;
      logic        idle;
   } obs_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   memory_bus_controller_if cpu ();

   logic [31:0] bus_addr, bus_wdata;
   logic [3:0]  bus_be;
   logic        bus_we;
   logic        rom_sel, ram_sel, io_sel, gfx_sel;
   logic        rom_cs, ram_cs, io_cs, gfx_cs;
   logic [31:0] rom_rdata = 32'd0, ram_rdata = 32'd0, io_rdata = 32'd0, gfx_rdata = 32'd0;
   logic        ram_ack;
   logic        stray_ack = 1'b0;
   int          ack_dly = 0;
   int          ram_cyc = 0;
   int          n_cmp = 0;
   int          n_bad = 0;

   assign rom_sel = (bus_addr[31:24] == 8'h00) || (bus_addr[31:24] == 8'h30);
   assign ram_sel = (bus_addr[31:24] == 8'h08);
   assign io_sel  = (bus_addr[31:24] == 8'h10) || (bus_addr[31:24] == 8'h30);
   assign gfx_sel = (bus_addr[31:24] == 8'h20);

   // RAM answers in the ack_dly-th cycle of ram_cs (0 = never).
   always @(posedge clk) ram_cyc <= ram_cs ? ram_cyc + 1 : 0;
   assign ram_ack = stray_ack | (ram_cs && ack_dly > 0 && ram_cyc == ack_dly - 1);

   memory_bus_controller #(
      .ROM_WAIT(ROM_W), .IO_WAIT(IO_W), .GFX_WAIT(GFX_W), .RAM_TIMEOUT(RAM_TO)
   ) dut (
      .clk(clk), .rst(rst), .cpu(cpu),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be), .bus_we(bus_we),
      .rom_sel(rom_sel), .ram_sel(ram_sel), .io_sel(io_sel), .gfx_sel(gfx_sel),
      .rom_cs(rom_cs), .ram_cs(ram_cs), .io_cs(io_cs), .gfx_cs(gfx_cs),
      .rom_rdata(rom_rdata), .ram_rdata(ram_rdata), .io_rdata(io_rdata),
      .gfx_rdata(gfx_rdata), .ram_ack(ram_ack)
   );

   // Reference: what one transaction must look like, from the address map,
   // the wait parameters and the RAM ack delay.
   function automatic obs_t model(logic [31:0] addr, logic wr, int dly);
      obs_t e;
      logic r, m, i, g;
      int   nsel, w, n;
      e      = '0;
      e.idle = 1'b1;
      r = (addr[31:24] == 8'h00) || (addr[31:24] == 8'h30);
      m = (addr[31:24] == 8'h08);
      i = (addr[31:24] == 8'h10) || (addr[31:24] == 8'h30);
      g = (addr[31:24] == 8'h20);
      nsel = int'(r) + int'(m) + int'(i) + int'(g);
      if (nsel != 1 || (r && wr)) begin
         e.lat = 2;
         e.err = 1'b1;
      end else if (m) begin
         if (dly >= 1 && dly <= RAM_TO + 1) begin
            n       = dly;
            e.rdata = wr ? 32'd0 : ram_rdata;
         end else begin
            n     = RAM_TO + 1;
            e.err = 1'b1;
         end
         e.c_ram = n;
         e.lat   = n + 1;
      end else begin
         w = r ? ROM_W : (i ? IO_W : GFX_W);
         if (r) e.c_rom = w + 1;
         else if (i) e.c_io = w + 1;
         else e.c_gfx = w + 1;
         e.lat   = w + 2;
         e.rdata = wr ? 32'd0 : (r ? rom_rdata : (i ? io_rdata : gfx_rdata));
      end
      e.we_n = wr ? (e.c_rom + e.c_ram + e.c_io + e.c_gfx) : 0;
      return e;
   endfunction

   function automatic string fmt(obs_t o, obs_t e);
      return $sformatf("lat %0d/%0d err %b/%b rdata %h/%h cs rom %0d/%0d ram %0d/%0d io %0d/%0d gfx %0d/%0d we %0d/%0d bus_bad %0d/%0d hold_bad %0d/%0d idle %b/%b (actual/required)",
         o.lat, e.lat, o.err, e.err, o.rdata, e.rdata, o.c_rom, e.c_rom, o.c_ram, e.c_ram,
         o.c_io, e.c_io, o.c_gfx, e.c_gfx, o.we_n, e.we_n, o.bad_bus, e.bad_bus,
         o.bad_hold, e.bad_hold, o.idle, e.idle);
   endfunction

   // Handshake a request; returns at the falling edge of the first cycle
   // after the handshake, with the request inputs scrambled.
   task automatic start_req(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                            input logic [3:0] be, output bit ok);
      int n;
      @(negedge clk);
      cpu.req_valid = 1'b1;
      cpu.req_write = wr;
      cpu.req_addr  = addr;
      cpu.req_wdata = wd;
      cpu.req_be    = be;
      n = 0;
      while (!cpu.req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      ok = cpu.req_ready;
      @(negedge clk);
      cpu.req_valid = 1'b0;
      cpu.req_write = 1'($urandom);
      cpu.req_addr  = $urandom;
      cpu.req_wdata = $urandom;
      cpu.req_be    = 4'($urandom);
   endtask

   task automatic do_txn(input logic [31:0] addr, input logic wr, input int dly,
                         input bit stray, input int hold, output obs_t o);
      bit          ok;
      int          k;
      logic [31:0] rd0;
      logic        er0;
      logic [31:0] wd;
      logic [3:0]  be;
      o         = '0;
      ack_dly   = dly;
      stray_ack = stray;
      wd        = $urandom;
      be        = 4'($urandom);
      start_req(addr, wr, wd, be, ok);
      if (!ok) begin
         o.lat = -1;
         stray_ack = 1'b0;
         return;
      end
      k = 1;
      while (!cpu.rsp_valid && k < 400) begin
         o.c_rom += int'(rom_cs);
         o.c_ram += int'(ram_cs);
         o.c_io  += int'(io_cs);
         o.c_gfx += int'(gfx_cs);
         o.we_n  += int'(bus_we);
         if (bus_addr !== addr || bus_wdata !== wd || bus_be !== be || cpu.req_ready !== 1'b0)
            o.bad_bus++;
         @(negedge clk);
         k++;
      end
      if (!cpu.rsp_valid) begin
         o.lat = -1;
         stray_ack = 1'b0;
         return;
      end
      o.lat   = k;
      o.rdata = cpu.rsp_rdata;
      o.err   = cpu.rsp_error;
      rd0     = cpu.rsp_rdata;
      er0     = cpu.rsp_error;
      for (int i = 0; i < hold; i++) begin
         if (cpu.rsp_valid !== 1'b1 || cpu.rsp_rdata !== rd0 || cpu.rsp_error !== er0 ||
             cpu.req_ready !== 1'b0 || {rom_cs, ram_cs, io_cs, gfx_cs, bus_we} !== 5'd0 ||
             bus_addr !== addr)
            o.bad_hold++;
         @(negedge clk);
      end
      cpu.rsp_ready = 1'b1;
      @(negedge clk);
      cpu.rsp_ready = 1'b0;
      o.idle    = cpu.req_ready && !cpu.rsp_valid;
      stray_ack = 1'b0;
   endtask

   task automatic test_reset;
      cpu.req_valid = 1'b1;
      cpu.req_write = 1'b1;
      cpu.req_addr  = 32'h0800_1234;
      cpu.req_wdata = 32'hA5A5_5A5A;
      cpu.req_be    = 4'hF;
      cpu.rsp_ready = 1'b0;
      rst = 1'b1;
      repeat (4) @(negedge clk);
      n_cmp++;
      if ({cpu.req_ready, cpu.rsp_valid, cpu.rsp_error, rom_cs, ram_cs, io_cs, gfx_cs, bus_we} !== 8'b1000_0000) begin
         n_bad++;
         $display("FAIL reset_ctrl: %b / 10000000", {cpu.req_ready, cpu.rsp_valid, cpu.rsp_error, rom_cs, ram_cs, io_cs, gfx_cs, bus_we});
      end
      n_cmp++;
      if ({bus_addr, bus_wdata, bus_be} !== 68'd0) begin
         n_bad++;
         $display("FAIL reset_bus: addr %h wdata %h be %h / all zero", bus_addr, bus_wdata, bus_be);
      end
      n_cmp++;
      if (cpu.rsp_rdata !== 32'd0) begin
         n_bad++;
         $display("FAIL reset_rdata: %h / 00000000", cpu.rsp_rdata);
      end
      cpu.req_valid = 1'b0;
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic run_dir(input string name, input logic [31:0] addr, input logic wr,
                          input int dly, input bit stray, input int hold);
      obs_t o, e;
      rom_rdata = $urandom;
      ram_rdata = $urandom;
      io_rdata  = $urandom;
      gfx_rdata = $urandom;
      do_txn(addr, wr, dly, stray, hold, o);
      e = model(addr, wr, dly);
      n_cmp++;
      if (o !== e) begin
         n_bad++;
         $display("FAIL %s: %s", name, fmt(o, e));
      end
   endtask

   task automatic test_fixed;
      obs_t o, e;
      rom_rdata = 32'h1234_5678;
      do_txn(32'h0000_0010, 1'b0, 0, 1'b0, 0, o);
      e = model(32'h0000_0010, 1'b0, 0);
      n_cmp++;
      if (o !== e || o.rdata !== 32'h1234_5678 || o.lat !== 3 || o.c_rom !== 2) begin
         n_bad++;
         $display("FAIL rom_read: %s", fmt(o, e));
      end
      run_dir("io_read", 32'h1000_0040, 1'b0, 0, 1'b0, 0);
      run_dir("io_write", 32'h1000_0044, 1'b1, 0, 1'b0, 0);
      run_dir("gfx_read", 32'h2000_0100, 1'b0, 0, 1'b0, 1);
      run_dir("gfx_write", 32'h2000_0104, 1'b1, 0, 1'b0, 0);
      run_dir("rom_read_stray_ack", 32'h00AB_CDE0, 1'b0, 0, 1'b1, 0);
   endtask

   task automatic test_ram;
      run_dir("ram_write_ack4", 32'h0800_0000, 1'b1, 4, 1'b0, 0);
      run_dir("ram_read_ack1", 32'h0800_0010, 1'b0, 1, 1'b0, 0);
      run_dir("ram_read_ack7", 32'h0812_3450, 1'b0, 7, 1'b0, 2);
      run_dir("ram_read_timeout", 32'h0800_0020, 1'b0, 0, 1'b0, 0);
      run_dir("ram_read_ack_last", 32'h0800_0030, 1'b0, RAM_TO + 1, 1'b0, 0);
      run_dir("ram_write_timeout", 32'h0800_0040, 1'b1, 0, 1'b0, 0);
   endtask

   task automatic test_faults;
      run_dir("unmapped_read", 32'h0200_0000, 1'b0, 0, 1'b0, 0);
      run_dir("rom_write", 32'h0000_0100, 1'b1, 0, 1'b0, 0);
      run_dir("multi_select", 32'h3000_0000, 1'b0, 0, 1'b0, 0);
      run_dir("unmapped_write_stray", 32'hF000_0008, 1'b1, 0, 1'b1, 1);
   endtask

   task automatic test_backpressure;
      run_dir("rom_hold5", 32'h0000_0200, 1'b0, 0, 1'b0, 5);
      run_dir("ram_hold5", 32'h0800_0200, 1'b0, 3, 1'b0, 5);
   endtask

   task automatic test_back_to_back;
      run_dir("b2b_ram", 32'h0800_0300, 1'b1, 2, 1'b0, 0);
      run_dir("b2b_io", 32'h1000_0300, 1'b0, 0, 1'b0, 0);
      run_dir("b2b_rom", 32'h0000_0300, 1'b0, 0, 1'b0, 0);
      run_dir("b2b_gfx", 32'h2000_0300, 1'b0, 0, 1'b0, 0);
   endtask

   task automatic test_reset_abort;
      bit ok;
      bit seen;
      ack_dly = 0;
      start_req(32'h0800_0040, 1'b0, 32'd0, 4'hF, ok);
      repeat (3) @(negedge clk);
      n_cmp++;
      if (ram_cs !== 1'b1) begin
         n_bad++;
         $display("FAIL abort_pre_cs: ram_cs %b / 1", ram_cs);
      end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({ram_cs, cpu.rsp_valid, cpu.req_ready, bus_we, cpu.rsp_error} !== 5'b00100 || bus_addr !== 32'd0) begin
         n_bad++;
         $display("FAIL abort_access: cs/valid/ready/we/err %b / 00100 addr %h / 0",
                  {ram_cs, cpu.rsp_valid, cpu.req_ready, bus_we, cpu.rsp_error}, bus_addr);
      end
      rst = 1'b0;
      seen = 1'b0;
      repeat (300) begin
         @(negedge clk);
         if (cpu.rsp_valid || ram_cs) seen = 1'b1;
      end
      n_cmp++;
      if (seen !== 1'b0) begin
         n_bad++;
         $display("FAIL abort_no_response: activity %b / 0", seen);
      end
      rom_rdata = 32'hCAFE_F00D;
      start_req(32'h0000_0020, 1'b0, 32'd0, 4'hF, ok);
      repeat (2) @(negedge clk);
      n_cmp++;
      if (cpu.rsp_valid !== 1'b1 || cpu.rsp_rdata !== 32'hCAFE_F00D) begin
         n_bad++;
         $display("FAIL abort_pre_rsp: valid %b rdata %h / 1 cafef00d", cpu.rsp_valid, cpu.rsp_rdata);
      end
      rst = 1'b1;
      @(negedge clk);
      n_cmp++;
      if ({cpu.rsp_valid, cpu.rsp_error, cpu.req_ready} !== 3'b001 || cpu.rsp_rdata !== 32'd0) begin
         n_bad++;
         $display("FAIL abort_respond: valid/err/ready %b / 001 rdata %h / 0",
                  {cpu.rsp_valid, cpu.rsp_error, cpu.req_ready}, cpu.rsp_rdata);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_random;
      logic [7:0]  tops [6];
      logic [31:0] addr;
      logic        wr;
      int          reg_i, dly, hold;
      bit          stray;
      tops = '{8'h00, 8'h08, 8'h10, 8'h20, 8'h02, 8'h30};
      for (int t = 0; t < 40; t++) begin
         reg_i = $urandom_range(0, 5);
         addr  = {tops[reg_i], 24'($urandom)};
         wr    = 1'($urandom);
         dly   = ($urandom_range(0, 11) == 0) ? 0 : $urandom_range(1, 10);
         stray = (reg_i != 1) && ($urandom_range(0, 3) == 0);
         hold  = $urandom_range(0, 3);
         run_dir($sformatf("random_%0d", t), addr, wr, dly, stray, hold);
      end
   endtask

   initial begin
      cpu.req_valid = 1'b0;
      cpu.req_write = 1'b0;
      cpu.req_addr  = 32'd0;
      cpu.req_wdata = 32'd0;
      cpu.req_be    = 4'd0;
      cpu.rsp_ready = 1'b0;
      test_reset();
      test_fixed();
      test_ram();
      test_faults();
      test_backpressure();
      test_back_to_back();
      test_reset_abort();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end
endmodule
